// File: rtl/bit_stuffer.sv
// USB transmit-path bit stuffer. It forwards the serial CRC/packet stream and
// inserts a 0 after every RUN_LEN consecutive 1s. While the stuffed bit is
// being emitted it drops ready for one cycle so the upstream holds its bit.
module bit_stuffer #(
    parameter int RUN_LEN = 6,
    parameter int CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pkt_start,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             stuffing,
    output logic [CNT_W-1:0] stuff_cnt
);

    localparam int OW = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
    localparam logic [OW-1:0] RUN_LAST = OW'(RUN_LEN - 1);

    typedef enum logic {PASS, STUFF} state_t;

    state_t           state_reg, state_next;
    logic [OW-1:0]    ones_cnt_reg, ones_cnt_next;
    logic [CNT_W-1:0] stuff_cnt_reg, stuff_cnt_next;
    // ready_reg is the inverse of the "stuff pending" flag: it is low exactly
    // while the STUFF cycle is in progress.
    logic             ready_reg, ready_next;
    logic             out_bit_reg, out_bit_next;
    logic             out_valid_reg, out_valid_next;
    logic             stuffing_reg, stuffing_next;
    logic [OW-1:0]    run_base;
    logic             accept;

    assign accept = in_valid && ready_reg;

    // Next-state and output decode; pkt_start clears the counters first so an
    // accepted bit in the same cycle counts from zero.
    always_comb begin
        state_next     = state_reg;
        ones_cnt_next  = ones_cnt_reg;
        stuff_cnt_next = stuff_cnt_reg;
        ready_next     = ready_reg;
        out_bit_next   = out_bit_reg;
        out_valid_next = 1'b0;
        stuffing_next  = 1'b0;
        run_base       = pkt_start ? '0 : ones_cnt_reg;

        if (pkt_start) begin
            ones_cnt_next  = '0;
            stuff_cnt_next = '0;
        end

        case (state_reg)
            PASS: begin
                if (accept) begin
                    out_bit_next   = in_bit;
                    out_valid_next = 1'b1;
                    if (!in_bit) begin
                        ones_cnt_next = '0;
                    end else if (run_base == RUN_LAST) begin
                        ones_cnt_next = '0;
                        ready_next    = 1'b0;
                        state_next    = STUFF;
                    end else begin
                        ones_cnt_next = run_base + 1'b1;
                    end
                end
            end
            STUFF: begin
                out_bit_next   = 1'b0;
                out_valid_next = 1'b1;
                stuffing_next  = 1'b1;
                // A coincident pkt_start clear wins over the increment.
                if (!pkt_start && (stuff_cnt_reg != '1)) begin
                    stuff_cnt_next = stuff_cnt_reg + 1'b1;
                end
                ready_next     = 1'b1;
                state_next     = PASS;
            end
            default: begin
                state_next = PASS;
                ready_next = 1'b1;
            end
        endcase
    end

    // State register; reset discards any pending stuff.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= PASS;
            ones_cnt_reg  <= '0;
            stuff_cnt_reg <= '0;
            ready_reg     <= 1'b1;
            out_bit_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            stuffing_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ones_cnt_reg  <= ones_cnt_next;
            stuff_cnt_reg <= stuff_cnt_next;
            ready_reg     <= ready_next;
            out_bit_reg   <= out_bit_next;
            out_valid_reg <= out_valid_next;
            stuffing_reg  <= stuffing_next;
        end
    end

    assign ready     = ready_reg;
    assign out_bit   = out_bit_reg;
    assign out_valid = out_valid_reg;
    assign stuffing  = stuffing_reg;
    assign stuff_cnt = stuff_cnt_reg;

endmodule
